// File: rtl/compare_alarm_fsm.sv
// Debounces comparator "A greater" flags into an alarm with hysteresis, edge pulses, GT count, one-hot error.
// Latency: one cycle; every output is registered and reflects the sample taken on the previous edge.
// No backpressure: a sample is consumed on every cycle with cmp_valid=1, and invalid cycles hold all state.
module compare_alarm_fsm #(
  parameter int unsigned ASSERT_CNT   = 3,
  parameter int unsigned DEASSERT_CNT = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmp_valid,
  input  logic             a_greater,
  input  logic             a_b_equal,
  input  logic             b_greater,
  input  logic             clr_count,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic [CNT_W-1:0] gt_count,
  output logic             err_onehot
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    ALARM     = 2'd2,
    RELEASING = 2'd3
  } state_e;

  localparam logic [3:0]       ASSERT_C   = 4'(ASSERT_CNT);
  localparam logic [3:0]       DEASSERT_C = 4'(DEASSERT_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       streak_q, streak_d;
  logic             alarm_q, alarm_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] gt_count_q, gt_count_d;

  logic       one_hot;
  logic       is_gt;
  logic       is_ngt;
  logic       is_bad;
  logic [3:0] streak_inc;

  assign one_hot    = $onehot({a_greater, a_b_equal, b_greater});
  assign is_gt      = cmp_valid & one_hot & a_greater;
  assign is_ngt     = cmp_valid & one_hot & ~a_greater;
  assign is_bad     = cmp_valid & ~one_hot;
  assign streak_inc = streak_q + 4'd1;

  // Next-state, streak and registered-output logic; malformed samples leave state and streak alone.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    err_d      = is_bad;
    gt_count_d = gt_count_q;

    case (state_q)
      IDLE: begin
        if (is_gt) begin
          if (ASSERT_C == 4'd1) begin
            state_d  = ALARM;
            streak_d = 4'd0;
            rise_d   = 1'b1;
          end else begin
            state_d  = ARMING;
            streak_d = 4'd1;
          end
        end
      end
      ARMING: begin
        if (is_gt) begin
          if (streak_inc == ASSERT_C) begin
            state_d  = ALARM;
            streak_d = 4'd0;
            rise_d   = 1'b1;
          end else begin
            streak_d = streak_inc;
          end
        end else if (is_ngt) begin
          state_d  = IDLE;
          streak_d = 4'd0;
        end
      end
      ALARM: begin
        if (is_ngt) begin
          if (DEASSERT_C == 4'd1) begin
            state_d  = IDLE;
            streak_d = 4'd0;
            fall_d   = 1'b1;
          end else begin
            state_d  = RELEASING;
            streak_d = 4'd1;
          end
        end
      end
      RELEASING: begin
        if (is_ngt) begin
          if (streak_inc == DEASSERT_C) begin
            state_d  = IDLE;
            streak_d = 4'd0;
            fall_d   = 1'b1;
          end else begin
            streak_d = streak_inc;
          end
        end else if (is_gt) begin
          // Falling back into ALARM is not a new rise, so no pulse here.
          state_d  = ALARM;
          streak_d = 4'd0;
        end
      end
      default: begin
        state_d  = IDLE;
        streak_d = 4'd0;
      end
    endcase

    alarm_d = (state_d == ALARM) || (state_d == RELEASING);

    // Clear wins over a same-cycle increment; the counter sticks at all-ones.
    if (clr_count) begin
      gt_count_d = '0;
    end else if (is_gt && (gt_count_q != CNT_MAX)) begin
      gt_count_d = gt_count_q + CNT_ONE;
    end
  end

  // State and output registers; reset drops alarm silently without a fall pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      alarm_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      err_q      <= 1'b0;
      gt_count_q <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      alarm_q    <= alarm_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      err_q      <= err_d;
      gt_count_q <= gt_count_d;
    end
  end

  assign alarm      = alarm_q;
  assign alarm_rise = rise_q;
  assign alarm_fall = fall_q;
  assign err_onehot = err_q;
  assign gt_count   = gt_count_q;

endmodule
